fetch_sequencer: RTL
====================

// Module: fetch_sequencer
// PURPOSE
//  Drives the 32-bit PC register (In/Signal_write) and consumes its Data output.
//  Fetches one instruction per PC value from instruction memory using a req/ack handshake.
//  Presents each instruction to decode with a valid/ready handshake.
//  Handles branch redirects and memory timeouts. Sits between the PC, instruction memory and decode.
// PARAMETERS
//  PC_STEP        4    increment applied to PC after a successful fetch
//  TIMEOUT_CYCLES 16   max WAIT cycles without Mem_ack before fault (>=2)
// PORTS
//  Clock_in       in   1   single clock, rising edge
//  Signal_reset   in   1   asynchronous, active-low reset
//  Pc_data        in   32  current PC value (PC register Data output)
//  Pc_in          out  32  next PC value (to PC register In)
//  Pc_write       out  1   one-cycle write strobe to PC register
//  Mem_addr       out  32  instruction memory address
//  Mem_req        out  1   read request, held until Mem_ack
//  Mem_ack        in   1   one-cycle response strobe; Mem_rdata valid with it
//  Mem_rdata      in   32  instruction word
//  Instr_out      out  32  fetched instruction
//  Instr_valid    out  1   Instr_out valid; held until Instr_ready
//  Instr_ready    in   1   decode accepts Instr_out
//  Branch_valid   in   1   one-cycle redirect request
//  Branch_target  in   32  redirect address
//  Fetch_fault    out  1   sticky: timeout or misaligned branch target
// BEHAVIOUR
//  - All outputs are registered. Reset (Signal_reset=0): all outputs are 0 and state=IDLE.
//    Reset mid-operation aborts any request immediately; Mem_req drops asynchronously.
//  - IDLE: lasts 1 cycle after reset release, then REQ.
//  - REQ: Mem_addr<=Pc_data; Mem_req<=1; timeout counter cleared; next state WAIT.
//  - WAIT: counter increments each cycle. On Mem_ack:
//      Mem_req<=0; Instr_out<=Mem_rdata; Instr_valid<=1;
//      Pc_in<=Mem_addr+PC_STEP (mod 2^32, wraps FFFFFFFC->00000000); Pc_write<=1; next state HOLD.
//    Counter reaching TIMEOUT_CYCLES without ack: Mem_req<=0, Fetch_fault<=1, state FAULT.
//  - HOLD: Instr_valid stays high and Instr_out stays stable. Transfer occurs when Instr_valid&Instr_ready.
//    On transfer, Instr_valid<=0 and next state REQ.
//    Minimum HOLD is 1 cycle, so the PC update is visible before REQ samples Pc_data.
//  - Fetch latency: REQ -> Instr_valid = 2 cycles + memory wait.
//  - Pc_write is high exactly 1 cycle per write; otherwise it is 0.
//  - Branch_valid (any state except FAULT/IDLE): Pc_in<=Branch_target; Pc_write<=1; Instr_valid<=0.
//      from REQ/HOLD -> REQ after 1 cycle (PC settle).
//      from WAIT without same-cycle ack -> FLUSH, Mem_req stays 1 until ack.
//      from WAIT with same-cycle ack -> data dropped, ack consumed, next state REQ.
//      Branch wins over the PC increment when both occur in the same cycle.
//  - FLUSH: waits for Mem_ack and discards Mem_rdata; the timeout still applies. Next state REQ.
//    A new Branch_valid in FLUSH rewrites Pc_in/Pc_write and stays in FLUSH.
//  - Branch_target[1:0]!=0: the redirect is ignored, Fetch_fault<=1, state FAULT.
//  - FAULT: all strobes are 0 and inputs are ignored. Exit is by reset only.
//  - Mem_ack outside WAIT/FLUSH is ignored.
// STRUCTURE
//  - Shared package fetch_pkg:
//      state encoding IDLE=0, REQ=1, WAIT=2, HOLD=3, FLUSH=4, FAULT=5 (3 bits);
//      PC_STEP default; width constant XLEN=32.
//  - Sub-module fetch_timeout_counter:
//      clear/enable inputs, TIMEOUT_CYCLES parameter, expired output;
//      $clog2(TIMEOUT_CYCLES+1)-bit counter that saturates at expiry.
//  - Remaining logic: FSM plus output registers in fetch_sequencer.
// TESTING (bench includes a behavioural PC register; count errors, print summary)
//  1 reset release, Pc_data=0, Mem_ack 2 cycles after Mem_req, Mem_rdata=8C010004
//    -> Mem_addr=0, Instr_out=8C010004, Instr_valid=1, Pc_in=4, one Pc_write pulse.
//  2 Instr_ready=0 for 5 cycles
//    -> Instr_valid/Instr_out stable, no new Mem_req;
//       Instr_ready=1 -> next Mem_addr=00000004.
//  3 Branch_valid with Branch_target=00000040 during WAIT, ack 3 cycles later
//    -> FLUSH, data dropped, Instr_valid stays 0, next Mem_addr=00000040.
//  4 Branch_valid and Mem_ack in the same cycle, target=00000100
//    -> Pc_in=00000100, no Instr_valid, next Mem_addr=00000100.
//  5 Pc_data=FFFFFFFC fetched -> Pc_in=00000000 (wrap).
//  6 no Mem_ack for TIMEOUT_CYCLES -> Fetch_fault=1, Mem_req=0, sticky;
//    Branch_target=00000042 -> Fetch_fault=1;
//    asserting Signal_reset=0 mid-WAIT -> all outputs 0 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: FSM state encoding, datapath width, default PC step.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: XLEN, PC_STEP_DEFAULT, fetch_state_t, word_aligned().
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP_DEFAULT = 32'd4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FLUSH = 3'd4,
    ST_FAULT = 3'd5
  } fetch_state_t;

  // Instruction addresses must be word aligned.
  function automatic logic word_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Counts cycles an instruction-memory request has been outstanding; flags expiry.
// Latency: expired is combinational on the registered count (same-cycle).
// Backpressure: none; clear has priority over enable.
// Ports: clk, rst_n (async active-low), clear, enable -> expired.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (enable && (cnt != LIMIT)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Asserted during the cycle whose increment brings the count to the limit,
  // so the owner can act on that same edge; stays asserted once saturated.
  assign expired = enable && (cnt >= LIMIT_M1);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: drives the PC register, fetches one word per PC over req/ack, hands it to decode.
// Latency: REQ -> Instr_valid is 2 cycles plus memory wait; PC update visible before the next REQ.
// Backpressure: Instr_valid/Instr_out held until Instr_ready; no new Mem_req while holding.
// Ports: Clock_in, Signal_reset (async active-low); PC reg: Pc_data in, Pc_in/Pc_write out;
//        memory: Mem_addr/Mem_req out, Mem_ack/Mem_rdata in; decode: Instr_out/Instr_valid out,
//        Instr_ready in; redirect: Branch_valid/Branch_target in; status: Fetch_fault (sticky).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] PC_STEP        = PC_STEP_DEFAULT,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic            Clock_in,
  input  logic            Signal_reset,
  input  logic [XLEN-1:0] Pc_data,
  output logic [XLEN-1:0] Pc_in,
  output logic            Pc_write,
  output logic [XLEN-1:0] Mem_addr,
  output logic            Mem_req,
  input  logic            Mem_ack,
  input  logic [XLEN-1:0] Mem_rdata,
  output logic [XLEN-1:0] Instr_out,
  output logic            Instr_valid,
  input  logic            Instr_ready,
  input  logic            Branch_valid,
  input  logic [XLEN-1:0] Branch_target,
  output logic            Fetch_fault
);

  fetch_state_t state;

  logic in_flight;
  logic redirect_ok;
  logic tmo_expired;
  logic fault_now;

  assign in_flight = (state == ST_WAIT) || (state == ST_FLUSH);

  // Redirects are only honoured in states that own the fetch stream.
  assign redirect_ok = (state inside {ST_REQ, ST_WAIT, ST_HOLD, ST_FLUSH});

  // A misaligned redirect or an expired outstanding request both kill the fetch path.
  assign fault_now = redirect_ok &&
                     ((Branch_valid && !word_aligned(Branch_target)) ||
                      (in_flight && !Mem_ack && tmo_expired));

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk     (Clock_in),
    .rst_n   (Signal_reset),
    .clear   (state == ST_REQ),
    .enable  (in_flight),
    .expired (tmo_expired)
  );

  always_ff @(posedge Clock_in or negedge Signal_reset) begin
    if (!Signal_reset) begin
      state       <= ST_IDLE;
      Pc_in       <= '0;
      Pc_write    <= 1'b0;
      Mem_addr    <= '0;
      Mem_req     <= 1'b0;
      Instr_out   <= '0;
      Instr_valid <= 1'b0;
      Fetch_fault <= 1'b0;
    end else begin
      Pc_write <= 1'b0;
      if (fault_now) begin
        Mem_req     <= 1'b0;
        Instr_valid <= 1'b0;
        Fetch_fault <= 1'b1;
        state       <= ST_FAULT;
      end else begin
        unique case (state)
          ST_IDLE: state <= ST_REQ;

          ST_REQ: begin
            if (Branch_valid) begin
              Pc_in    <= Branch_target;
              Pc_write <= 1'b1;
            end else if (!Pc_write) begin
              // A write issued last cycle lands in the PC register on this edge,
              // so Pc_data is only trusted once no write is in flight.
              Mem_addr <= Pc_data;
              Mem_req  <= 1'b1;
              state    <= ST_WAIT;
            end
          end

          ST_WAIT: begin
            if (Branch_valid) begin
              Pc_in       <= Branch_target;
              Pc_write    <= 1'b1;
              Instr_valid <= 1'b0;
              if (Mem_ack) begin
                Mem_req <= 1'b0;
                state   <= ST_REQ;
              end else begin
                state <= ST_FLUSH;
              end
            end else if (Mem_ack) begin
              Mem_req     <= 1'b0;
              Instr_out   <= Mem_rdata;
              Instr_valid <= 1'b1;
              Pc_in       <= Mem_addr + PC_STEP;
              Pc_write    <= 1'b1;
              state       <= ST_HOLD;
            end
          end

          ST_HOLD: begin
            if (Branch_valid) begin
              Pc_in       <= Branch_target;
              Pc_write    <= 1'b1;
              Instr_valid <= 1'b0;
              state       <= ST_REQ;
            end else if (Instr_ready) begin
              Instr_valid <= 1'b0;
              state       <= ST_REQ;
            end
          end

          ST_FLUSH: begin
            if (Branch_valid) begin
              Pc_in    <= Branch_target;
              Pc_write <= 1'b1;
            end
            // Response to the abandoned request is swallowed.
            if (Mem_ack) begin
              Mem_req <= 1'b0;
              state   <= ST_REQ;
            end
          end

          default: state <= ST_FAULT;
        endcase
      end
    end
  end

endmodule
